// File: rtl/data_bus_pkg.sv
// Shared types and constants for the data-side bus master.
package data_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int BUS_WIDTH   = 32;
  localparam int BEAT_OFFSET = 4;

endpackage

// File: rtl/bus_watchdog.sv
// Beat watchdog: counts strobe cycles without a response and pulses expire
// in the TIMEOUT_CYCLES-th such cycle. Reloads whenever strobe is low or a
// response arrives, so each new strobe starts a fresh window.
module bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic stb,
  input  logic resp,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Down-counter, reloaded outside an outstanding strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= LOAD;
    end else if (!stb || resp) begin
      cnt <= LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = stb & ~resp & (cnt == '0);

endmodule

// File: rtl/data_bus_ctrl.sv
// Data-side bus master: splits a 64-bit load/store into up to two 32-bit
// beats (LO lane, then HI lane), reports err/timeout as a one-cycle fault.
module data_bus_ctrl
  import data_bus_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [63:0] ERR_READ_VALUE = '1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 data_read_in,
  input  logic                 data_write_in,
  input  logic [7:0]           data_write_mask_in,
  input  logic [63:0]          data_address_in,
  input  logic [63:0]          data_write_value_in,
  output logic [63:0]          data_read_value_out,
  output logic                 stall_out,
  output logic                 fault_out,
  output logic                 bus_cyc_out,
  output logic                 bus_stb_out,
  output logic                 bus_we_out,
  output logic [63:0]          bus_adr_out,
  output logic [3:0]           bus_sel_out,
  output logic [BUS_WIDTH-1:0] bus_dat_out,
  input  logic [BUS_WIDTH-1:0] bus_dat_in,
  input  logic                 bus_ack_in,
  input  logic                 bus_err_in
);

  state_t       state, state_next;
  logic         cyc, cyc_next;
  logic         stb, stb_next;
  logic [63:3]  addr;
  logic [63:0]  wval;
  logic [7:0]   mask;
  logic         is_write;
  logic         fault;
  logic [63:0]  rdata;

  logic request, capture, lane_hi, hi_needed;
  logic beat_ok, beat_fail, expire;
  logic unused_addr_bits;

  assign unused_addr_bits = ^data_address_in[2:0];

  assign request   = data_read_in | data_write_in;
  assign capture   = (state == IDLE) & request;
  assign lane_hi   = (state == HI);
  assign hi_needed = ~is_write | (mask[7:4] != 4'h0);
  assign beat_ok   = stb & bus_ack_in & ~bus_err_in;
  assign beat_fail = (stb & bus_err_in) | expire;

  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .rst   (reset),
    .stb   (stb),
    .resp  (bus_ack_in | bus_err_in),
    .expire(expire)
  );

  // State and bus handshake registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cyc   <= 1'b0;
      stb   <= 1'b0;
    end else begin
      state <= state_next;
      cyc   <= cyc_next;
      stb   <= stb_next;
    end
  end

  // Next state; stb drops for one cycle after a LO ack and is re-raised in HI.
  always_comb begin
    state_next = state;
    cyc_next   = cyc;
    stb_next   = stb;
    case (state)
      IDLE: begin
        if (request) begin
          if (data_read_in || (data_write_mask_in[3:0] != 4'h0)) begin
            state_next = LO;
            cyc_next   = 1'b1;
            stb_next   = 1'b1;
          end else if (data_write_mask_in[7:4] != 4'h0) begin
            state_next = HI;
            cyc_next   = 1'b1;
            stb_next   = 1'b1;
          end else begin
            state_next = DONE;
          end
        end
      end
      LO: begin
        if (beat_fail) begin
          state_next = DONE;
          cyc_next   = 1'b0;
          stb_next   = 1'b0;
        end else if (beat_ok) begin
          if (hi_needed) begin
            state_next = HI;
            stb_next   = 1'b0;
          end else begin
            state_next = DONE;
            cyc_next   = 1'b0;
            stb_next   = 1'b0;
          end
        end
      end
      HI: begin
        if (!stb) begin
          stb_next = 1'b1;
        end else if (beat_fail || beat_ok) begin
          state_next = DONE;
          cyc_next   = 1'b0;
          stb_next   = 1'b0;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cyc_next   = 1'b0;
        stb_next   = 1'b0;
      end
    endcase
  end

  // Request latch, read-lane capture and fault bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr     <= '0;
      wval     <= '0;
      mask     <= '0;
      is_write <= 1'b0;
      fault    <= 1'b0;
      rdata    <= '0;
    end else begin
      if (capture) begin
        addr     <= data_address_in[63:3];
        wval     <= data_write_value_in;
        mask     <= data_write_mask_in;
        is_write <= data_write_in;
        fault    <= 1'b0;
      end
      if (beat_ok && !is_write) begin
        if (lane_hi) rdata[63:32] <= bus_dat_in;
        else         rdata[31:0]  <= bus_dat_in;
      end
      if (beat_fail) begin
        fault <= 1'b1;
        if (!is_write) rdata <= ERR_READ_VALUE;
      end
    end
  end

  assign stall_out           = request & (state != DONE);
  assign fault_out           = (state == DONE) & fault;
  assign data_read_value_out = rdata;

  assign bus_cyc_out = cyc;
  assign bus_stb_out = stb;
  assign bus_we_out  = cyc & is_write;
  assign bus_adr_out = cyc ? ({addr, 3'b000} + (lane_hi ? 64'(BEAT_OFFSET) : 64'd0)) : 64'd0;
  assign bus_sel_out = !cyc     ? 4'h0 :
                       !is_write ? 4'hF :
                       lane_hi  ? mask[7:4] : mask[3:0];
  assign bus_dat_out = cyc ? (lane_hi ? wval[63:32] : wval[31:0]) : '0;

endmodule
